// File: rtl/fc_capture_fifo_if.sv
// PicoSoC iomem bus bundle for the frequency-counter capture FIFO.
// The SoC side is the master; the capture block is the slave.
interface fc_capture_fifo_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/fc_capture_fifo.sv
// Frequency-counter capture FIFO: each cap_valid pushes NCH count words plus an
// epoch tag; firmware drains samples over the iomem bus and gets a level IRQ.
module fc_capture_fifo #(
  parameter int         NCH        = 3,
  parameter int         WIDTH      = 32,
  parameter int         DEPTH      = 4,
  parameter int         EPOCH_BITS = 8,
  parameter logic [7:0] BASE       = 8'h03
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cap_valid,
  input  logic [NCH*WIDTH-1:0]   cap_data,
  fc_capture_fifo_if.slave       bus,
  output logic                   irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [5:0] W_STATUS = 6'd0;
  localparam logic [5:0] W_CTRL   = 6'd1;
  localparam logic [5:0] W_EPOCH  = 6'd2;
  localparam logic [5:0] W_POP    = 6'd3;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  enable_q, enable_d;
  logic                  irq_en_q, irq_en_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic [NCH*WIDTH-1:0]  data_mem [DEPTH];
  logic [EPOCH_BITS-1:0] tag_mem  [DEPTH];

  // Bus decode
  logic       match, accept, is_wr, is_rd;
  logic [5:0] word;
  logic       ctrl_wr, pop_wr, flush, clr;

  assign match   = (bus.iomem_addr[31:24] == BASE);
  assign accept  = bus.iomem_valid && !ready_q && match;
  assign is_wr   = accept && (bus.iomem_wstrb != 4'h0);
  assign is_rd   = accept && (bus.iomem_wstrb == 4'h0);
  assign word    = bus.iomem_addr[7:2];
  assign ctrl_wr = is_wr && (word == W_CTRL) && bus.iomem_wstrb[0];
  assign pop_wr  = is_wr && (word == W_POP);
  assign flush   = ctrl_wr && bus.iomem_wdata[2];
  assign clr     = ctrl_wr && bus.iomem_wdata[3];

  // FIFO control; flush overrides any same-cycle push or pop.
  logic empty, full, push_req, pop, do_push, drop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign push_req = cap_valid && enable_q;
  assign pop      = pop_wr && !empty && !flush;
  assign do_push  = push_req && (!full || pop_wr) && !flush;
  assign drop     = push_req && full && !pop_wr && !flush;

  // Read mux samples current state, i.e. before this cycle's push/pop.
  logic [31:0]          rd_word;
  logic [NCH*WIDTH-1:0] head_data;

  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    rd_word = '0;
    case (word)
      W_STATUS: begin
        rd_word[4:0]   = 5'(level_q);
        rd_word[8]     = empty;
        rd_word[9]     = full;
        rd_word[10]    = overflow_q;
        rd_word[23:16] = drop_cnt_q;
      end
      W_CTRL:  rd_word[1:0] = {irq_en_q, enable_q};
      W_EPOCH: if (!empty) rd_word = 32'(tag_mem[rd_ptr_q]);
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (!empty && word == 6'(4 + k)) rd_word = 32'(head_data[k*WIDTH +: WIDTH]);
        end
      end
    endcase
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    epoch_d    = epoch_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    ready_d    = accept;
    rdata_d    = is_rd ? rd_word : rdata_q;
    irq_d      = irq_en_q && !empty;

    if (push_req) epoch_d = epoch_q + EPOCH_BITS'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop in the same cycle as a clear is kept rather than lost.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end

    if (ctrl_wr) begin
      enable_d = bus.iomem_wdata[0];
      irq_en_d = bus.iomem_wdata[1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      epoch_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      enable_q   <= 1'b1;
      irq_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      epoch_q    <= epoch_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  // NOTE: storage is not reset; the level counter guarantees no entry is
  // read before it has been written, and reads of an empty FIFO return 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= cap_data;
      tag_mem[wr_ptr_q]  <= epoch_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq             = irq_q;

  // Address bits between the base byte and the word index, and the upper
  // write-data bits, carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.iomem_addr[23:8], bus.iomem_addr[1:0], bus.iomem_wdata[31:4]};

endmodule

// File: tb/tb_fc_capture_fifo.sv
// Directed bench for fc_capture_fifo (NCH=3, WIDTH=32, DEPTH=4, EPOCH_BITS=2).
module tb_fc_capture_fifo;
  localparam int NCH = 3;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int EB = 2;

  localparam logic [31:0] A_STATUS = 32'h0300_0000;
  localparam logic [31:0] A_CTRL   = 32'h0300_0004;
  localparam logic [31:0] A_EPOCH  = 32'h0300_0008;
  localparam logic [31:0] A_POP    = 32'h0300_000C;
  localparam logic [31:0] A_CH0    = 32'h0300_0010;
  localparam logic [31:0] A_CH1    = 32'h0300_0014;
  localparam logic [31:0] A_CH2    = 32'h0300_0018;
  localparam logic [31:0] A_CH3    = 32'h0300_001C;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 cap_valid = 1'b0;
  logic [NCH*WIDTH-1:0] cap_data = '0;
  logic                 irq;

  int n_pass = 0;
  int n_total = 0;

  fc_capture_fifo_if bus_if ();

  fc_capture_fifo #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .EPOCH_BITS(EB), .BASE(8'h03)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .cap_valid(cap_valid),
    .cap_data(cap_data),
    .bus(bus_if),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus access; the acknowledge itself is a comparison (bounded wait).
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = addr;
    bus_if.iomem_wstrb = wstrb;
    bus_if.iomem_wdata = wdata;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = bus_if.iomem_ready;
    end
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    rdata = bus_if.iomem_rdata;
    n_total++;
    if (!got) $display("FAIL bus_ack addr=%h: iomem_ready=0 after 4 cycles, required 1", addr);
    else n_pass++;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_access(addr, 4'hF, wdata, dummy);
  endtask

  task automatic capture(input logic [31:0] c0);
    @(posedge clk); #1;
    cap_valid = 1'b1;
    cap_data  = {c0 + 32'h2000, c0 + 32'h1000, c0};
    @(posedge clk); #1;
    cap_valid = 1'b0;
  endtask

  // Bus write accepted on the same edge as a capture strobe.
  task automatic write_with_capture(input string name, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] c0);
    @(posedge clk); #1;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = addr;
    bus_if.iomem_wstrb = 4'hF;
    bus_if.iomem_wdata = wdata;
    cap_valid = 1'b1;
    cap_data  = {c0 + 32'h2000, c0 + 32'h1000, c0};
    @(posedge clk); #1;
    cap_valid = 1'b0;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    n_total++;
    if (bus_if.iomem_ready !== 1'b1)
      $display("FAIL %s_ack: iomem_ready=%b, required 1", name, bus_if.iomem_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [3] = '{A_STATUS, A_CTRL, A_EPOCH};
    logic [31:0] exps  [3] = '{32'h0000_0100, 32'h0000_0001, 32'h0};
    bit seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (irq !== 1'b0 || bus_if.iomem_ready !== 1'b0 || bus_if.iomem_rdata !== 32'h0)
      $display("FAIL reset_outputs: irq=%b ready=%b rdata=%h, required 0/0/0",
               irq, bus_if.iomem_ready, bus_if.iomem_rdata);
    else n_pass++;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_access(addrs[i], 4'h0, 32'h0, d);
      n_total++;
      if (d !== exps[i]) $display("FAIL reset_read[%0d]: got %h, required %h", i, d, exps[i]);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_total++;
    if (bus_if.iomem_ready !== 1'b0) $display("FAIL ready_pulse: ready=%b one cycle after ack, required 0", bus_if.iomem_ready);
    else n_pass++;
    // Out-of-range base must never be acknowledged.
    @(posedge clk); #1;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = 32'h0400_0000;
    bus_if.iomem_wstrb = 4'h0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) seen = 1'b1;
    end
    bus_if.iomem_valid = 1'b0;
    n_total++;
    if (seen) $display("FAIL out_of_range: iomem_ready seen=1, required 0");
    else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [31:0] d;
    logic [31:0] addrs [8] = '{A_STATUS, A_EPOCH, A_CH0, A_CH1, A_CH2, A_CH3, A_POP, A_CTRL};
    logic [31:0] exps  [8] = '{32'h1, 32'h1, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h3};
    bus_write(A_CTRL, 32'h3);
    @(posedge clk); #1;
    @(posedge clk);
    @(posedge clk); #1;
    cap_valid = 1'b1;
    cap_data  = {32'h33, 32'h22, 32'h11};
    @(posedge clk); #1;
    cap_valid = 1'b0;
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_t1: irq=%b one cycle after capture, required 0", irq);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_t2: irq=%b two cycles after capture, required 1", irq);
    else n_pass++;
    // Write to a read-only register must change nothing.
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      bus_access(addrs[i], 4'h0, 32'h0, d);
      n_total++;
      if (d !== exps[i]) $display("FAIL head_read[%0d]: got %h, required %h", i, d, exps[i]);
      else n_pass++;
    end
    bus_write(A_POP, 32'h0);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_pop_t1: irq=%b right after POP ack, required 1", irq);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_pop_t2: irq=%b after POP emptied FIFO, required 0", irq);
    else n_pass++;
    bus_write(A_POP, 32'h0);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h100) $display("FAIL pop_empty_status: got %h, required %h", d, 32'h100);
    else n_pass++;
    bus_access(A_CH0, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL empty_ch0: got %h, required 0", d);
    else n_pass++;
  endtask

  // Epoch counter is 1 here; six captures tag 2,3,0,1,(2),(3) and the last two drop.
  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) capture(32'h100 + 32'(i));
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h0002_0604) $display("FAIL overflow_status: got %h, required %h", d, 32'h0002_0604);
    else n_pass++;
    bus_access(A_EPOCH, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h2) $display("FAIL overflow_head_epoch: got %h, required 2", d);
    else n_pass++;
    bus_access(A_CH0, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h100) $display("FAIL overflow_head_ch0: got %h, required 100", d);
    else n_pass++;
    bus_write(A_CTRL, 32'h9);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h0000_0204) $display("FAIL clear_status: got %h, required %h", d, 32'h204);
    else n_pass++;
    bus_access(A_CTRL, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL clear_ctrl: got %h, required 1", d);
    else n_pass++;
  endtask

  // FIFO holds tags 2,3,0,1; epoch counter 3. POP + capture: new tail tag 0.
  task automatic test_full_pop_push();
    logic [31:0] d;
    logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h0, 32'h0};
    logic [31:0] ch0s [4] = '{32'h102, 32'h103, 32'hAA, 32'h0};
    write_with_capture("pop_push", A_POP, 32'h0, 32'hAA);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h0000_0204) $display("FAIL pop_push_status: got %h, required %h", d, 32'h204);
    else n_pass++;
    bus_access(A_EPOCH, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h3) $display("FAIL pop_push_head: got %h, required 3", d);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus_write(A_POP, 32'h0);
      bus_access(A_EPOCH, 4'h0, 32'h0, d);
      n_total++;
      if (d !== tags[i]) $display("FAIL drain_epoch[%0d]: got %h, required %h", i, d, tags[i]);
      else n_pass++;
      bus_access(A_CH0, 4'h0, 32'h0, d);
      n_total++;
      if (d !== ch0s[i]) $display("FAIL drain_ch0[%0d]: got %h, required %h", i, d, ch0s[i]);
      else n_pass++;
    end
  endtask

  // Epoch counter 0: five captures tag 1,2,3,0,1; then flush beats a push.
  task automatic test_epoch_wrap();
    logic [31:0] d;
    logic [31:0] tags [5] = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h1};
    for (int i = 0; i < 5; i++) begin
      capture(32'h200 + 32'(i));
      bus_access(A_EPOCH, 4'h0, 32'h0, d);
      n_total++;
      if (d !== tags[i]) $display("FAIL wrap_epoch[%0d]: got %h, required %h", i, d, tags[i]);
      else n_pass++;
      bus_access(A_CH2, 4'h0, 32'h0, d);
      n_total++;
      if (d !== 32'h2200 + 32'(i)) $display("FAIL wrap_ch2[%0d]: got %h, required %h", i, d, 32'h2200 + 32'(i));
      else n_pass++;
      bus_write(A_POP, 32'h0);
    end
    capture(32'h300);
    capture(32'h301);
    write_with_capture("flush_push", A_CTRL, 32'h5, 32'h302);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h100) $display("FAIL flush_status: got %h, required %h", d, 32'h100);
    else n_pass++;
    capture(32'h303);
    bus_access(A_EPOCH, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL flush_epoch_advanced: got %h, required 1", d);
    else n_pass++;
  endtask

  // One entry (tag 1) present; disabled capture must not push or tick epoch.
  task automatic test_disable();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h0);
    capture(32'h400);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL disabled_status: got %h, required 1", d);
    else n_pass++;
    bus_write(A_CTRL, 32'h3);
    capture(32'h401);
    bus_write(A_POP, 32'h0);
    bus_access(A_EPOCH, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h2) $display("FAIL reenabled_epoch: got %h, required 2", d);
    else n_pass++;
    capture(32'h402);
    bus_access(A_STATUS, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h2 || irq !== 1'b1) $display("FAIL two_entries: status=%h irq=%b, required 2/1", d, irq);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] addrs [3] = '{A_STATUS, A_CTRL, A_EPOCH};
    logic [31:0] exps  [3] = '{32'h100, 32'h1, 32'h0};
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = A_STATUS;
    bus_if.iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_if.iomem_ready) seen = 1'b1;
    end
    n_total++;
    if (seen || irq !== 1'b0 || bus_if.iomem_rdata !== 32'h0)
      $display("FAIL reset_mid: ready_seen=%b irq=%b rdata=%h, required 0/0/0", seen, irq, bus_if.iomem_rdata);
    else n_pass++;
    bus_if.iomem_valid = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_access(addrs[i], 4'h0, 32'h0, d);
      n_total++;
      if (d !== exps[i]) $display("FAIL post_reset[%0d]: got %h, required %h", i, d, exps[i]);
      else n_pass++;
    end
    capture(32'h500);
    bus_access(A_EPOCH, 4'h0, 32'h0, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL post_reset_epoch: got %h, required 1", d);
    else n_pass++;
  endtask

  initial begin
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wdata = 32'h0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_pop_push();
    test_epoch_wrap();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
